mem_readback: RTL and testbench

- Reads stored pattern data back out of DDR2 SDRAM through a dedicated MCB read port.
- Unpacks each 64-bit MCB word into two 32-bit words, restoring the byte order the host originally wrote.
- Pushes those words into the host pipeOut FIFO write side, so the host can verify pattern memory contents after the write path finishes.
- Runs entirely in mem_clk. The pipeOut FIFO is external and dual-clock.

---
 rtl/mem_readback.sv | 216 +++++++++++++++++++++
 tb/tb_mem_readback.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback.sv
// mem_readback: streams pattern memory back out of DDR2 through MCB port 2
// and into the host pipeOut FIFO. Each 64-bit MCB word becomes two 32-bit
// pipeOut words (high half first), each byte-swapped back into the order
// the host originally wrote. Everything runs in mem_clk.
//
// Strobe semantics: c3_p2_cmd_en, c3_p2_rd_en and pout_wr_en are
// single-cycle, registered strobes. A command is issued only in a cycle
// where c3_p2_cmd_full was low when the decision was made. A word is popped
// only when c3_p2_rd_empty was low; rd_data is first-word-fall-through, so
// the head word is consumed in the same decision that pops it. pout_wr_en
// never checks for space: room for a whole burst was confirmed through
// pout_prog_full before the burst's command went out.
module mem_readback #(
  parameter logic [29:0] BASE_ADDR     = 30'h08,
  parameter int          RD_BURST_LEN  = 32,
  parameter int          WORDS_PER_PAT = 720
) (
  input  logic        mem_clk,
  input  logic        fsm_rst,
  input  logic        mem_calib_done,
  input  logic        rb_start,
  input  logic [31:0] Num_Pat,
  output logic        rb_busy,
  output logic        rb_done,
  output logic        rb_error,
  output logic        c3_p2_cmd_en,
  output logic [2:0]  c3_p2_cmd_instr,
  output logic [5:0]  c3_p2_cmd_bl,
  output logic [29:0] c3_p2_cmd_byte_addr,
  input  logic        c3_p2_cmd_full,
  output logic        c3_p2_rd_en,
  input  logic        c3_p2_rd_empty,
  input  logic [6:0]  c3_p2_rd_count,
  input  logic        c3_p2_rd_overflow,
  input  logic        c3_p2_rd_error,
  input  logic [63:0] c3_p2_rd_data,
  output logic        pout_wr_en,
  output logic [31:0] pout_data,
  input  logic        pout_prog_full,
  output logic [2:0]  dbg_state,
  output logic [6:0]  dbg_rd_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_XFER_HI = 3'd2,
    S_XFER_LO = 3'd3,
    S_NEXT    = 3'd4
  } state_t;

  localparam logic [6:0]  BURST_MAX = 7'(RD_BURST_LEN);
  localparam logic [32:0] PAT_WORDS = 33'(WORDS_PER_PAT);
  localparam logic [2:0]  INSTR_RD  = 3'b001;

  state_t      state_q, state_d;
  logic [32:0] words_left_q, words_left_d;
  logic [6:0]  burst_left_q, burst_left_d;
  logic [6:0]  burst_n_q, burst_n_d;
  logic [31:0] lo_half_q, lo_half_d;
  logic        cmd_en_q, cmd_en_d;
  logic [2:0]  cmd_instr_q, cmd_instr_d;
  logic [5:0]  cmd_bl_q, cmd_bl_d;
  logic [29:0] cmd_addr_q, cmd_addr_d;
  logic        rd_en_q, rd_en_d;
  logic        pout_wr_en_q, pout_wr_en_d;
  logic [31:0] pout_data_q, pout_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [32:0] word_total;
  logic [6:0]  burst_n;

  function automatic logic [31:0] byteswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    burst_left_d = burst_left_q;
    burst_n_d    = burst_n_q;
    lo_half_d    = lo_half_q;
    cmd_instr_d  = cmd_instr_q;
    cmd_bl_d     = cmd_bl_q;
    cmd_addr_d   = cmd_addr_q;
    pout_data_d  = pout_data_q;
    busy_d       = busy_q;
    error_d      = error_q;
    cmd_en_d     = 1'b0;
    rd_en_d      = 1'b0;
    pout_wr_en_d = 1'b0;
    done_d       = 1'b0;

    word_total = ({1'b0, Num_Pat} + 33'd2) * PAT_WORDS;
    burst_n    = (words_left_q < {26'd0, BURST_MAX}) ? words_left_q[6:0] : BURST_MAX;

    case (state_q)
      S_IDLE: begin
        if (!c3_p2_rd_empty) begin
          // Drain leftovers one pop at a time: the empty flag only reflects
          // a pop one cycle after it, so pop every other cycle.
          rd_en_d = !rd_en_q;
        end else if (rb_start && mem_calib_done) begin
          words_left_d = word_total;
          cmd_addr_d   = BASE_ADDR;
          error_d      = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_CMD;
        end
      end
      S_CMD: begin
        if (!c3_p2_cmd_full && !pout_prog_full) begin
          cmd_en_d     = 1'b1;
          cmd_instr_d  = INSTR_RD;
          cmd_bl_d     = 6'(burst_n - 7'd1);
          burst_left_d = burst_n;
          burst_n_d    = burst_n;
          state_d      = S_XFER_HI;
        end
      end
      S_XFER_HI: begin
        if (!c3_p2_rd_empty) begin
          pout_wr_en_d = 1'b1;
          pout_data_d  = byteswap(c3_p2_rd_data[63:32]);
          lo_half_d    = c3_p2_rd_data[31:0];
          rd_en_d      = 1'b1;
          state_d      = S_XFER_LO;
        end
      end
      S_XFER_LO: begin
        pout_wr_en_d = 1'b1;
        pout_data_d  = byteswap(lo_half_q);
        burst_left_d = burst_left_q - 7'd1;
        words_left_d = words_left_q - 33'd1;
        state_d      = (burst_left_q == 7'd1) ? S_NEXT : S_XFER_HI;
      end
      S_NEXT: begin
        if (words_left_q == 33'd0) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cmd_addr_d = BASE_ADDR;
          state_d    = S_IDLE;
        end else begin
          cmd_addr_d = cmd_addr_q + {20'd0, burst_n_q, 3'b000};
          state_d    = S_CMD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A read-FIFO fault abandons the readback; the IDLE drain tidies up.
    if (state_q != S_IDLE && (c3_p2_rd_overflow || c3_p2_rd_error)) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      error_d      = 1'b1;
      cmd_en_d     = 1'b0;
      rd_en_d      = 1'b0;
      pout_wr_en_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge mem_clk) begin
    if (fsm_rst) begin
      state_q      <= S_IDLE;
      words_left_q <= 33'd0;
      burst_left_q <= 7'd0;
      burst_n_q    <= 7'd0;
      lo_half_q    <= 32'd0;
      cmd_en_q     <= 1'b0;
      cmd_instr_q  <= 3'd0;
      cmd_bl_q     <= 6'd0;
      cmd_addr_q   <= BASE_ADDR;
      rd_en_q      <= 1'b0;
      pout_wr_en_q <= 1'b0;
      pout_data_q  <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      burst_left_q <= burst_left_d;
      burst_n_q    <= burst_n_d;
      lo_half_q    <= lo_half_d;
      cmd_en_q     <= cmd_en_d;
      cmd_instr_q  <= cmd_instr_d;
      cmd_bl_q     <= cmd_bl_d;
      cmd_addr_q   <= cmd_addr_d;
      rd_en_q      <= rd_en_d;
      pout_wr_en_q <= pout_wr_en_d;
      pout_data_q  <= pout_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rb_busy             = busy_q;
  assign rb_done             = done_q;
  assign rb_error            = error_q;
  assign c3_p2_cmd_en        = cmd_en_q;
  assign c3_p2_cmd_instr     = cmd_instr_q;
  assign c3_p2_cmd_bl        = cmd_bl_q;
  assign c3_p2_cmd_byte_addr = cmd_addr_q;
  assign c3_p2_rd_en         = rd_en_q;
  assign pout_wr_en          = pout_wr_en_q;
  assign pout_data           = pout_data_q;
  assign dbg_state           = state_q;
  assign dbg_rd_count        = c3_p2_rd_count;

endmodule

// File: tb/tb_mem_readback.sv
// tb_mem_readback: directed bench for mem_readback with a small MCB read
// port model (command -> words queued in a first-word-fall-through FIFO).
module tb_mem_readback;

  localparam logic [2:0]  ST_IDLE = 3'd0;
  localparam logic [2:0]  ST_CMD  = 3'd1;
  localparam logic [2:0]  ST_XHI  = 3'd2;
  localparam logic [63:0] FIXED_WORD = 64'h0011223344556677;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        fsm_rst = 1'b1;
  logic        mem_calib_done = 1'b0;
  logic        rb_start = 1'b0;
  logic [31:0] num_pat = 32'd0;
  logic        cmd_full = 1'b0;
  logic        rd_overflow = 1'b0;
  logic        rd_err = 1'b0;
  logic        prog_full = 1'b0;
  logic        rd_empty = 1'b1;
  logic [6:0]  rd_count = 7'd0;
  logic [63:0] rd_data = 64'd0;

  logic        rb_busy, rb_done, rb_error, cmd_en, rd_en, pout_wr_en;
  logic [2:0]  cmd_instr, dbg_state;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic [31:0] pout_data;
  logic [6:0]  dbg_rd_count;

  mem_readback dut (
    .mem_clk(clk), .fsm_rst(fsm_rst), .mem_calib_done(mem_calib_done),
    .rb_start(rb_start), .Num_Pat(num_pat),
    .rb_busy(rb_busy), .rb_done(rb_done), .rb_error(rb_error),
    .c3_p2_cmd_en(cmd_en), .c3_p2_cmd_instr(cmd_instr), .c3_p2_cmd_bl(cmd_bl),
    .c3_p2_cmd_byte_addr(cmd_addr), .c3_p2_cmd_full(cmd_full),
    .c3_p2_rd_en(rd_en), .c3_p2_rd_empty(rd_empty), .c3_p2_rd_count(rd_count),
    .c3_p2_rd_overflow(rd_overflow), .c3_p2_rd_error(rd_err),
    .c3_p2_rd_data(rd_data),
    .pout_wr_en(pout_wr_en), .pout_data(pout_data), .pout_prog_full(prog_full),
    .dbg_state(dbg_state), .dbg_rd_count(dbg_rd_count)
  );

  // memory contents as seen through the read port
  function automatic logic [63:0] pat_word(input logic [29:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // MCB model state and observation logs (owned by the model process)
  logic [63:0] fifo_q[$];
  logic [29:0] cmd_addr_obs[$];
  logic [5:0]  cmd_bl_obs[$];
  logic [31:0] pout_obs[$];
  int          pout_cyc[$];
  logic        pend_pop = 1'b0;
  logic        pend_cmd = 1'b0;
  logic [29:0] pend_addr = 30'd0;
  logic [5:0]  pend_bl = 6'd0;
  int          cyc = 0;
  int          rd_en_cnt = 0;
  int          done_cnt = 0;
  int          data_mode = 0;

  // Model runs on the falling edge; strobes seen in one cycle take effect
  // in the next, like a FIFO that updates on the edge after the request.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pend_cmd)
      for (int i = 0; i <= int'(pend_bl); i++)
        fifo_q.push_back((data_mode != 0) ? FIXED_WORD : pat_word(pend_addr + 30'(8 * i)));
    pend_pop  = rd_en;
    pend_cmd  = cmd_en;
    pend_addr = cmd_addr;
    pend_bl   = cmd_bl;
    if (cmd_en) begin
      cmd_addr_obs.push_back(cmd_addr);
      cmd_bl_obs.push_back(cmd_bl);
    end
    if (pout_wr_en) begin
      pout_obs.push_back(pout_data);
      pout_cyc.push_back(cyc);
    end
    if (rd_en) rd_en_cnt = rd_en_cnt + 1;
    if (rb_done) done_cnt = done_cnt + 1;
    rd_empty = (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() == 0) ? 64'd0 : fifo_q[0];
    rd_count = (fifo_q.size() > 127) ? 7'd127 : 7'(fifo_q.size());
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      $error("check %s mismatched", tag);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] get_addr(input int idx);
    return (idx < cmd_addr_obs.size()) ? {34'd0, cmd_addr_obs[idx]} : 'x;
  endfunction

  function automatic logic [63:0] get_bl(input int idx);
    return (idx < cmd_bl_obs.size()) ? {58'd0, cmd_bl_obs[idx]} : 'x;
  endfunction

  function automatic logic [63:0] get_pout(input int idx);
    return (idx < pout_obs.size()) ? {32'd0, pout_obs[idx]} : 'x;
  endfunction

  function automatic logic [63:0] get_pcyc(input int idx);
    return (idx < pout_cyc.size()) ? 64'(pout_cyc[idx]) : 'x;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_en"}, cmd_en, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_pout_wr"}, pout_wr_en, 0);
    check({tag, "_done"}, rb_done, 0);
    check({tag, "_busy"}, rb_busy, 0);
    check({tag, "_error"}, rb_error, 0);
    check({tag, "_instr"}, cmd_instr, 0);
    check({tag, "_bl"}, cmd_bl, 0);
    check({tag, "_addr"}, cmd_addr, 30'h08);
    check({tag, "_pdata"}, pout_data, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Full readback of num_pat patterns with address/burst/data checks.
  task automatic full_run(input string tag, input logic [31:0] np, input int ncmd,
                          input logic [5:0] last_bl, input int budget);
    int c0, p0, d0, nw;
    c0 = cmd_addr_obs.size();
    p0 = pout_obs.size();
    d0 = done_cnt;
    nw = (int'(np) + 2) * 720;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      logic [63:0] w;
      w = pat_word(30'h08 + 30'(8 * i));
      exp_q.push_back(swap32(w[63:32]));
      exp_q.push_back(swap32(w[31:0]));
    end
    num_pat = np;
    rb_start = 1'b1;
    step(1);
    rb_start = 1'b0;
    check({tag, "_busy_start"}, rb_busy, 1);
    for (int g = 0; g < budget && done_cnt == d0; g++) step(1);
    check({tag, "_done_seen"}, done_cnt != d0, 1);
    step(3);
    check({tag, "_ncmd"}, cmd_addr_obs.size() - c0, ncmd);
    for (int k = 0; k < ncmd; k++) begin
      check({tag, "_addr"}, get_addr(c0 + k), 64'(30'h08 + 30'(256 * k)));
      check({tag, "_bl"}, get_bl(c0 + k), (k == ncmd - 1) ? last_bl : 6'd31);
    end
    check({tag, "_nwr"}, pout_obs.size() - p0, 2 * nw);
    for (int i = 0; i < 2 * nw; i++)
      check({tag, "_data"}, get_pout(p0 + i), {32'd0, exp_q[i]});
    check({tag, "_rate"}, get_pcyc(p0 + 2) - get_pcyc(p0), 2);
    check({tag, "_ndone"}, done_cnt - d0, 1);
    check({tag, "_busy_end"}, rb_busy, 0);
    check({tag, "_state_end"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int c0, p0, d0, r0;

    // reset values
    step(3);
    check_reset_vals("rst");
    check("rst_rdcount", dbg_rd_count, rd_count);
    fsm_rst = 1'b0;
    step(2);

    // start ignored before calibration
    rb_start = 1'b1;
    step(1);
    rb_start = 1'b0;
    step(2);
    check("nocal_busy", rb_busy, 0);
    check("nocal_cmds", cmd_addr_obs.size(), 0);
    mem_calib_done = 1'b1;
    step(2);

    // complete readbacks
    full_run("np0", 32'd0, 45, 6'd31, 4000);
    full_run("np1", 32'd1, 68, 6'd15, 6000);

    // pipeOut back-pressure, then command FIFO back-pressure, fixed data
    data_mode = 1;
    c0 = cmd_addr_obs.size();
    p0 = pout_obs.size();
    d0 = done_cnt;
    num_pat = 32'd0;
    prog_full = 1'b1;
    rb_start = 1'b1;
    step(1);
    rb_start = 1'b0;
    step(100);
    check("pf_nocmd", cmd_addr_obs.size() - c0, 0);
    check("pf_state", dbg_state, ST_CMD);
    prog_full = 1'b0;
    step(1);
    check("pf_cmd_en", cmd_en, 1);
    check("pf_instr", cmd_instr, 3'b001);
    check("pf_addr", cmd_addr, 30'h08);
    check("pf_bl", cmd_bl, 6'd31);
    cmd_full = 1'b1;
    for (int g = 0; g < 200 && dbg_state != ST_CMD; g++) step(1);
    check("cf_reach_cmd", dbg_state, ST_CMD);
    step(100);
    check("cf_nocmd", cmd_addr_obs.size() - c0, 1);
    check("cf_cmd_en_low", cmd_en, 0);
    cmd_full = 1'b0;
    step(1);
    check("cf_cmd_en", cmd_en, 1);
    check("cf_addr", cmd_addr, 30'h108);
    check("swap_hi", get_pout(p0), 32'h33221100);
    check("swap_lo", get_pout(p0 + 1), 32'h77665544);
    check("swap_adjacent", get_pcyc(p0 + 1) - get_pcyc(p0), 1);

    // read error mid-burst aborts without rb_done
    step(10);
    rd_err = 1'b1;
    step(1);
    rd_err = 1'b0;
    check("err_flag", rb_error, 1);
    check("err_busy", rb_busy, 0);
    check("err_state", dbg_state, ST_IDLE);
    for (int g = 0; g < 200 && !(rd_empty && !rd_en); g++) step(1);
    check("err_drained", rd_empty, 1);
    step(5);
    check("err_nodone", done_cnt - d0, 0);
    check("err_sticky", rb_error, 1);
    check("err_nowr_drain", pout_wr_en, 0);

    // restart clears the error and begins at the base address
    data_mode = 0;
    c0 = cmd_addr_obs.size();
    rb_start = 1'b1;
    step(1);
    rb_start = 1'b0;
    check("rs_err_clear", rb_error, 0);
    check("rs_busy", rb_busy, 1);
    for (int g = 0; g < 50 && cmd_addr_obs.size() == c0; g++) step(1);
    check("rs_first_addr", get_addr(c0), 30'h08);
    rb_start = 1'b1;
    step(1);
    rb_start = 1'b0;
    for (int g = 0; g < 200 && cmd_addr_obs.size() <= c0 + 1; g++) step(1);
    check("rs_busy_start_ignored", get_addr(c0 + 1), 30'h108);

    // reset with 20 words left in the read FIFO
    for (int g = 0; g < 200 && !(fifo_q.size() == 20 && !rd_en && dbg_state == ST_XHI); g++) step(1);
    check("mr_fifo20", fifo_q.size(), 20);
    d0 = done_cnt;
    r0 = rd_en_cnt;
    p0 = pout_obs.size();
    fsm_rst = 1'b1;
    step(1);
    check_reset_vals("mr");
    fsm_rst = 1'b0;
    for (int g = 0; g < 100 && !rd_empty; g++) step(1);
    step(5);
    check("mr_fifo_empty", rd_empty, 1);
    check("mr_rd_pulses", rd_en_cnt - r0, 20);
    check("mr_no_writes", pout_obs.size() - p0, 0);
    check("mr_no_done", done_cnt - d0, 0);
    check("mr_busy", rb_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
